// File: rtl/cpu_core.sv
// cpu_core: 5-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with internal program ROM.
// No forwarding or interlocks; pipeline state advances on each rise of the divided CLK_SYS.

module cpu_core_mul (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] product_o
);
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;

    // Shift-add step; the first partial product is folded into the load so all 32 steps
    // finish one CLK before the next CLK_SYS rise.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = b_i[0] ? a_i : 32'd0;
            mcand_d  = a_i << 1;
            mplier_d = b_i >> 1;
            cnt_d    = 5'd31;
        end else if (cnt_q != 5'd0) begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 5'd1;
        end else begin
            acc_d    = acc_q;
            cnt_d    = 5'd0;
        end
    end

    // Multiplier state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 5'd0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product_o = acc_q;
endmodule

module cpu_core #(
    parameter int ROM_DEPTH = 32,
    parameter int DIV       = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Prog_BUS_READ,
    input  logic [31:0] Data_BUS_READ,
    output logic [31:0] ADDR,
    output logic        CS,
    output logic        CS_P,
    output logic        WR_RD,
    output logic [31:0] Data_BUS_WRITE
);
    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int IW   = $clog2(ROM_DEPTH);
    localparam int PCW  = IW + 2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A, FN_MUL = 6'h18;
    localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                           ALU_AND  = 4'd3, ALU_OR  = 4'd4, ALU_SLT = 4'd5;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       is_mul;
        logic       spare;
    } ctrl_t;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] rom_word(input logic [IW-1:0] idx);
        logic [31:0] w;
        case (idx)
            IW'(0), IW'(11):  w = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd4001);
            IW'(1), IW'(12):  w = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2001);
            IW'(2), IW'(13):  w = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd5001);
            IW'(3), IW'(14):  w = enc_i(OP_ADDI, 5'd0, 5'd4, 16'd3001);
            IW'(4), IW'(18):  w = enc_r(5'd1, 5'd2, 5'd5, FN_SUB);
            IW'(5), IW'(19):  w = enc_r(5'd3, 5'd4, 5'd6, FN_SUB);
            IW'(6), IW'(23):  w = enc_r(5'd5, 5'd6, 5'd7, FN_MUL);
            IW'(7), IW'(27):  w = enc_i(OP_SW, 5'd0, 5'd7, 16'h2F0F);
            default:          w = 32'd0;
        endcase
        return w;
    endfunction

    logic [CW-1:0]  div_cnt_q, div_cnt_d;
    logic           clk_sys_q, clk_sys_d;
    logic           sys_rise_s;
    logic           cs_p_q;
    logic [PCW-1:0] pc_q;
    logic [31:0]    ifid_instr_q;
    ctrl_t          ctrl_s, idex_ctrl_q, exmem_ctrl_q, memwb_ctrl_q;
    logic [31:0]    rf_q [32];
    logic [31:0]    rs_val_s, rt_val_s, imm_s;
    logic [4:0]     dst_s;
    logic [31:0]    idex_a_q, idex_b_q, idex_imm_q;
    logic [4:0]     idex_dst_q, exmem_dst_q, memwb_dst_q;
    logic [31:0]    alu_b_s, alu_s, ex_res_s, mul_prod_s;
    logic [31:0]    exmem_res_q, exmem_store_q;
    logic [31:0]    memwb_res_q, memwb_load_q, wb_val_s;
    logic           unused_s;

    // CLK_SYS divider: toggles every HALF CLK edges, starts low out of reset.
    always_comb begin
        if (div_cnt_q == CW'(HALF - 1)) begin
            div_cnt_d = '0;
            clk_sys_d = ~clk_sys_q;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
            clk_sys_d = clk_sys_q;
        end
    end

    assign sys_rise_s = (div_cnt_q == CW'(HALF - 1)) && !clk_sys_q;

    // Divider and program-select registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt_q <= '0;
            clk_sys_q <= 1'b0;
            cs_p_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_sys_q <= clk_sys_d;
            cs_p_q    <= 1'b1;
        end
    end

    // ID decode into the control word.
    always_comb begin
        ctrl_s = '0;
        case (ifid_instr_q[31:26])
            OP_RTYPE: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
                case (ifid_instr_q[5:0])
                    FN_ADD:  ctrl_s.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_s.alu_op = ALU_SUB;
                    FN_AND:  ctrl_s.alu_op = ALU_AND;
                    FN_OR:   ctrl_s.alu_op = ALU_OR;
                    FN_SLT:  ctrl_s.alu_op = ALU_SLT;
                    FN_MUL:  ctrl_s.is_mul = 1'b1;
                    default: ctrl_s = '0;
                endcase
            end
            OP_ADDI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALU_ADD;
            end
            OP_LW: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.alu_op     = ALU_ADD;
                ctrl_s.mem_rd     = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_s.alu_src = 1'b1;
                ctrl_s.alu_op  = ALU_ADD;
                ctrl_s.mem_wr  = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // r0 is never written, so reading it directly yields zero.
    assign rs_val_s = rf_q[ifid_instr_q[25:21]];
    assign rt_val_s = rf_q[ifid_instr_q[20:16]];
    assign imm_s    = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign dst_s    = ctrl_s.reg_dst ? ifid_instr_q[15:11] : ifid_instr_q[20:16];

    cpu_core_mul u_mul (
        .clk_i     (CLK),
        .rst_n_i   (RST),
        .start_i   (sys_rise_s && ctrl_s.is_mul),
        .a_i       (rs_val_s),
        .b_i       (rt_val_s),
        .product_o (mul_prod_s)
    );

    // EX-stage ALU.
    always_comb begin
        alu_b_s = idex_ctrl_q.alu_src ? idex_imm_q : idex_b_q;
        case (idex_ctrl_q.alu_op)
            ALU_ADD: alu_s = idex_a_q + alu_b_s;
            ALU_SUB: alu_s = idex_a_q - alu_b_s;
            ALU_AND: alu_s = idex_a_q & alu_b_s;
            ALU_OR:  alu_s = idex_a_q | alu_b_s;
            ALU_SLT: alu_s = {31'd0, $signed(idex_a_q) < $signed(alu_b_s)};
            default: alu_s = 32'd0;
        endcase
        ex_res_s = idex_ctrl_q.is_mul ? mul_prod_s : alu_s;
    end

    assign wb_val_s = memwb_ctrl_q.mem_to_reg ? memwb_load_q : memwb_res_q;

    // Pipeline registers and PC, advanced on CLK_SYS rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q          <= '0;
            ifid_instr_q  <= 32'd0;
            idex_ctrl_q   <= '0;
            idex_a_q      <= 32'd0;
            idex_b_q      <= 32'd0;
            idex_imm_q    <= 32'd0;
            idex_dst_q    <= 5'd0;
            exmem_ctrl_q  <= '0;
            exmem_res_q   <= 32'd0;
            exmem_store_q <= 32'd0;
            exmem_dst_q   <= 5'd0;
            memwb_ctrl_q  <= '0;
            memwb_res_q   <= 32'd0;
            memwb_load_q  <= 32'd0;
            memwb_dst_q   <= 5'd0;
        end else if (sys_rise_s) begin
            pc_q          <= pc_q + PCW'(4);
            ifid_instr_q  <= rom_word(pc_q[PCW-1:2]);
            idex_ctrl_q   <= ctrl_s;
            idex_a_q      <= rs_val_s;
            idex_b_q      <= rt_val_s;
            idex_imm_q    <= imm_s;
            idex_dst_q    <= dst_s;
            exmem_ctrl_q  <= idex_ctrl_q;
            exmem_res_q   <= ex_res_s;
            exmem_store_q <= idex_b_q;
            exmem_dst_q   <= idex_dst_q;
            memwb_ctrl_q  <= exmem_ctrl_q;
            memwb_res_q   <= exmem_res_q;
            memwb_load_q  <= exmem_ctrl_q.mem_rd ? Data_BUS_READ : 32'd0;
            memwb_dst_q   <= exmem_dst_q;
        end
    end

    // Register file write at the rise that ends WB; no write-through to ID.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (sys_rise_s && memwb_ctrl_q.reg_write && (memwb_dst_q != 5'd0)) begin
            rf_q[memwb_dst_q] <= wb_val_s;
        end
    end

    assign ADDR           = exmem_res_q;
    assign CS             = exmem_ctrl_q.mem_rd | exmem_ctrl_q.mem_wr;
    assign WR_RD          = exmem_ctrl_q.mem_wr;
    assign Data_BUS_WRITE = exmem_ctrl_q.mem_wr ? exmem_store_q : 32'd0;
    assign CS_P           = cs_p_q;

    assign unused_s = ^{Prog_BUS_READ, ifid_instr_q[10:6], idex_ctrl_q, exmem_ctrl_q, memwb_ctrl_q};
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: architectural model with hazard visibility distance, randomized buses,
// randomized multiplier operands and randomized mid-MUL reset point.

module tb_cpu_core;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Prog_BUS_READ, Data_BUS_READ;
    logic [31:0] ADDR, Data_BUS_WRITE;
    logic        CS, CS_P, WR_RD;

    logic        mul_rst_n, mul_start;
    logic [31:0] mul_a, mul_b, mul_p;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    cpu_core dut (
        .CLK(CLK), .RST(RST), .Prog_BUS_READ(Prog_BUS_READ), .Data_BUS_READ(Data_BUS_READ),
        .ADDR(ADDR), .CS(CS), .CS_P(CS_P), .WR_RD(WR_RD), .Data_BUS_WRITE(Data_BUS_WRITE)
    );

    cpu_core_mul u_mul_tb (
        .clk_i(CLK), .rst_n_i(mul_rst_n), .start_i(mul_start),
        .a_i(mul_a), .b_i(mul_b), .product_o(mul_p)
    );

    localparam int K_NOP = 0, K_ADDI = 1, K_SUB = 2, K_MUL = 3, K_SW = 4;

    typedef struct packed {
        int          idx;
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    int          kind_m [32];
    int          dst_m  [32];
    int          rs_m   [32];
    int          rt_m   [32];
    logic [15:0] imm_m  [32];
    logic [31:0] arch   [32];
    wr_t         pend   [$];

    task automatic set_op(input int w, input int k, input int dst, input int rs, input int rt,
                          input logic [15:0] imm);
        kind_m[w] = k; dst_m[w] = dst; rs_m[w] = rs; rt_m[w] = rt; imm_m[w] = imm;
    endtask

    task automatic build_program();
        for (int w = 0; w < 32; w++) set_op(w, K_NOP, 0, 0, 0, 16'd0);
        for (int p = 0; p < 2; p++) begin
            set_op(p * 11 + 0, K_ADDI, 1, 0, 1, 16'd4001);
            set_op(p * 11 + 1, K_ADDI, 2, 0, 2, 16'd2001);
            set_op(p * 11 + 2, K_ADDI, 3, 0, 3, 16'd5001);
            set_op(p * 11 + 3, K_ADDI, 4, 0, 4, 16'd3001);
        end
        set_op(4, K_SUB, 5, 1, 2, 16'd0);   set_op(18, K_SUB, 5, 1, 2, 16'd0);
        set_op(5, K_SUB, 6, 3, 4, 16'd0);   set_op(19, K_SUB, 6, 3, 4, 16'd0);
        set_op(6, K_MUL, 7, 5, 6, 16'd0);   set_op(23, K_MUL, 7, 5, 6, 16'd0);
        set_op(7, K_SW, 0, 0, 7, 16'h2F0F); set_op(27, K_SW, 0, 0, 7, 16'h2F0F);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) arch[r] = 32'd0;
        pend.delete();
    endtask

    // Instruction g sees a result only if its producer issued at least 4 slots earlier.
    task automatic model_step(input int g, output logic [31:0] e_addr, output logic e_cs,
                              output logic e_wr, output logic [31:0] e_dbw);
        int w;
        logic [31:0] a, b, res, sext;
        wr_t nw;
        while (pend.size() > 0 && pend[0].idx <= g - 4) begin
            arch[pend[0].rd] = pend[0].val;
            void'(pend.pop_front());
        end
        w    = g % 32;
        a    = arch[rs_m[w]];
        b    = arch[rt_m[w]];
        sext = {{16{imm_m[w][15]}}, imm_m[w]};
        e_cs = 1'b0; e_wr = 1'b0; e_dbw = 32'd0; res = 32'd0;
        case (kind_m[w])
            K_ADDI:  res = a + sext;
            K_SUB:   res = a - b;
            K_MUL:   res = a * b;
            K_SW:    begin res = a + sext; e_cs = 1'b1; e_wr = 1'b1; e_dbw = b; end
            default: res = 32'd0;
        endcase
        if (kind_m[w] == K_ADDI || kind_m[w] == K_SUB || kind_m[w] == K_MUL) begin
            nw.idx = g; nw.rd = 5'(dst_m[w]); nw.val = res;
            if (dst_m[w] != 0) pend.push_back(nw);
        end
        e_addr = res;
    endtask

    initial begin
        Data_BUS_READ = 32'd0;
        Prog_BUS_READ = 32'd0;
        forever begin
            @(negedge CLK);
            Data_BUS_READ = $urandom;
            Prog_BUS_READ = $urandom;
        end
    end

    task automatic test_reset();
        RST = 1'b0; mul_rst_n = 1'b0; mul_start = 1'b0; mul_a = 32'd0; mul_b = 32'd0;
        repeat (20) @(posedge CLK);
        #1;
        vectors++;
        if (ADDR !== 32'd0 || CS !== 1'b0 || CS_P !== 1'b0 || WR_RD !== 1'b0 || Data_BUS_WRITE !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: ADDR=%h CS=%b CS_P=%b WR_RD=%b DBW=%h, required all 0",
                     ADDR, CS, CS_P, WR_RD, Data_BUS_WRITE);
        end
    endtask

    task automatic test_mul();
        logic [31:0] exp;
        @(negedge CLK); mul_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (i == 0)      begin mul_a = 32'hFFFF_FFFF; mul_b = 32'd2;     end
            else if (i == 1) begin mul_a = 32'd65536;     mul_b = 32'd65536; end
            else             begin mul_a = $urandom;      mul_b = $urandom;  end
            exp = (i == 0) ? 32'hFFFF_FFFE : (i == 1) ? 32'd0 : mul_a * mul_b;
            mul_start = 1'b1;
            @(posedge CLK); #1; mul_start = 1'b0;
            repeat (31) @(posedge CLK);
            #1;
            vectors++;
            if (mul_p !== exp) begin
                miscompares++;
                $display("FAIL mul_%0d: %h*%h got %h, required %h", i, mul_a, mul_b, mul_p, exp);
            end
        end
    endtask

    // Releases reset, then checks the MEM-stage bus at every CLK_SYS rise against the model.
    task automatic test_pipeline_run(input string tag, input int n_rises);
        logic [31:0] e_addr, e_dbw, pin;
        logic        e_cs, e_wr;
        int          g;
        @(negedge CLK); RST = 1'b1; model_reset();
        repeat (15) @(posedge CLK);
        #1;
        vectors++;
        if (CS_P !== 1'b1 || CS !== 1'b0 || ADDR !== 32'd0 || WR_RD !== 1'b0 || Data_BUS_WRITE !== 32'd0) begin
            miscompares++;
            $display("FAIL %s_pre_rise: CS_P=%b CS=%b ADDR=%h WR_RD=%b DBW=%h, required 1 0 0 0 0",
                     tag, CS_P, CS, ADDR, WR_RD, Data_BUS_WRITE);
        end
        for (int n = 1; n <= n_rises; n++) begin
            if (n == 1) @(posedge CLK);
            else repeat (32) @(posedge CLK);
            #1;
            g = n - 3;
            if (g < 0) begin
                e_addr = 32'd0; e_cs = 1'b0; e_wr = 1'b0; e_dbw = 32'd0;
            end else begin
                model_step(g, e_addr, e_cs, e_wr, e_dbw);
            end
            vectors++;
            if (ADDR !== e_addr || CS !== e_cs || WR_RD !== e_wr || Data_BUS_WRITE !== e_dbw || CS_P !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_rise%0d: ADDR=%h CS=%b WR_RD=%b DBW=%h CS_P=%b, required %h %b %b %h 1",
                         tag, n, ADDR, CS, WR_RD, Data_BUS_WRITE, CS_P, e_addr, e_cs, e_wr, e_dbw);
            end
            if (g == 7 || g == 27 || g == 39) begin
                pin = (g == 7) ? 32'd0 : 32'd4000000;
                vectors++;
                if (ADDR !== 32'h0000_2F0F || CS !== 1'b1 || WR_RD !== 1'b1 || Data_BUS_WRITE !== pin) begin
                    miscompares++;
                    $display("FAIL %s_store_g%0d: ADDR=%h CS=%b WR_RD=%b DBW=%0d, required 2f0f 1 1 %0d",
                             tag, g, ADDR, CS, WR_RD, Data_BUS_WRITE, pin);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int off;
        @(negedge CLK); RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        repeat (16 + 32 * 24) @(posedge CLK);
        off = $urandom_range(2, 30);
        repeat (off) @(posedge CLK);
        #3; RST = 1'b0;
        #1;
        vectors++;
        if (ADDR !== 32'd0 || CS !== 1'b0 || CS_P !== 1'b0 || WR_RD !== 1'b0 || Data_BUS_WRITE !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_mul_reset_off%0d: ADDR=%h CS=%b CS_P=%b WR_RD=%b DBW=%h, required all 0",
                     off, ADDR, CS, CS_P, WR_RD, Data_BUS_WRITE);
        end
        repeat (4) @(posedge CLK);
    endtask

    initial begin
        build_program();
        test_reset();
        test_mul();
        test_pipeline_run("pass", 45);
        test_reset_mid_mul();
        test_pipeline_run("restart", 12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
